// File: rtl/fighter_motion.sv
// Per-fighter position controller: synchronised buttons in, registered top-left
// sprite coordinate out, updated once per unfrozen frame tick.
module fighter_motion #(
    parameter int unsigned START_X  = 8,
    parameter int unsigned SPRITE_W = 12,
    parameter int unsigned SPRITE_H = 20,
    parameter int unsigned SCREEN_W = 96,
    parameter int unsigned SCREEN_H = 64,
    parameter int unsigned STEP     = 2,
    parameter int unsigned JUMP_V0  = 6,
    parameter int unsigned GRAVITY  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       freeze,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [7:0] x_pos,
    output logic [7:0] y_pos,
    output logic       airborne,
    output logic [1:0] state
);

    localparam int unsigned GROUND_Y = SCREEN_H - 1 - SPRITE_H;
    localparam int unsigned X_MAX    = SCREEN_W - 1 - SPRITE_W;

    localparam logic [8:0] GroundY9  = 9'(GROUND_Y);
    localparam logic [8:0] XMax9     = 9'(X_MAX);
    localparam logic [8:0] Step9     = 9'(STEP);
    localparam logic [8:0] Grav9     = 9'(GRAVITY);
    localparam logic [8:0] TakeoffY9 = 9'(GROUND_Y - JUMP_V0);
    localparam logic [3:0] Vel0      = 4'(JUMP_V0 - GRAVITY);

    typedef enum logic [1:0] {
        StGround = 2'd0,
        StRise   = 2'd1,
        StFall   = 2'd2
    } state_e;

    // Bit order: {jump, right, left}
    logic [2:0] btn_s1_q, btn_s2_q;
    logic       jump_prev_q, jump_req_q, jump_req_d;
    logic       jump_rise, jump_now;

    state_e     state_q, state_d;
    logic [7:0] x_q, x_d, y_q, y_d;
    logic [3:0] vel_q, vel_d;
    logic       airborne_q;

    logic [8:0] x_ext, y_ext, vel_ext, nv;
    logic       left, right;

    assign left      = btn_s2_q[0];
    assign right     = btn_s2_q[1];
    assign jump_rise = btn_s2_q[2] & ~jump_prev_q;
    assign jump_now  = jump_req_q | jump_rise;
    // A pending request never survives a tick or a freeze.
    assign jump_req_d = (frame_tick || freeze) ? 1'b0 : (jump_req_q | jump_rise);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q    <= 3'b000;
            btn_s2_q    <= 3'b000;
            jump_prev_q <= 1'b0;
            jump_req_q  <= 1'b0;
        end else begin
            btn_s1_q    <= {btn_jump, btn_right, btn_left};
            btn_s2_q    <= btn_s1_q;
            jump_prev_q <= btn_s2_q[2];
            jump_req_q  <= jump_req_d;
        end
    end

    always_comb begin
        x_ext = {1'b0, x_q};
        x_d   = x_q;
        if (left && !right) begin
            x_d = (x_ext < Step9) ? 8'd0 : 8'(x_ext - Step9);
        end else if (right && !left) begin
            x_d = (x_ext + Step9 > XMax9) ? 8'(XMax9) : 8'(x_ext + Step9);
        end
    end

    always_comb begin
        y_ext   = {1'b0, y_q};
        vel_ext = {5'b00000, vel_q};
        nv      = vel_ext + Grav9;
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        case (state_q)
            StGround: begin
                if (jump_now) begin
                    y_d = 8'(TakeoffY9);
                    if (JUMP_V0 <= GRAVITY) begin
                        state_d = StFall;
                        vel_d   = 4'd0;
                    end else begin
                        state_d = StRise;
                        vel_d   = Vel0;
                    end
                end
            end
            StRise: begin
                if (y_ext < vel_ext) begin
                    state_d = StFall;
                    y_d     = 8'd0;
                    vel_d   = 4'd0;
                end else begin
                    y_d = 8'(y_ext - vel_ext);
                    if (vel_ext <= Grav9) begin
                        state_d = StFall;
                        vel_d   = 4'd0;
                    end else begin
                        vel_d = 4'(vel_ext - Grav9);
                    end
                end
            end
            StFall: begin
                if (y_ext + nv >= GroundY9) begin
                    state_d = StGround;
                    y_d     = 8'(GroundY9);
                    vel_d   = 4'd0;
                end else begin
                    y_d   = 8'(y_ext + nv);
                    vel_d = (nv > 9'd15) ? 4'hf : nv[3:0];
                end
            end
            default: begin
                state_d = StGround;
                y_d     = 8'(GroundY9);
                vel_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StGround;
            x_q        <= 8'(START_X);
            y_q        <= 8'(GroundY9);
            vel_q      <= 4'd0;
            airborne_q <= 1'b0;
        end else if (frame_tick && !freeze) begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            vel_q      <= vel_d;
            airborne_q <= (state_d != StGround);
        end
    end

    assign x_pos    = x_q;
    assign y_pos    = y_q;
    assign airborne = airborne_q;
    assign state    = state_q;

endmodule

// File: tb/tb_fighter_motion.sv
// Bench for fighter_motion: per-tick vector table with a scoreboard queue, plus a
// ceiling-clamp instance and an asynchronous reset check.
module tb_fighter_motion;

    logic       clk = 1'b0;
    logic       rst_n, frame_tick, freeze, btn_left, btn_right, btn_jump;
    logic [7:0] xa, ya, xb, yb;
    logic       aa, ab;
    logic [1:0] sa, sb_st;

    always #5 clk = ~clk;

    fighter_motion dut_a (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .freeze(freeze),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .x_pos(xa), .y_pos(ya), .airborne(aa), .state(sa)
    );

    // Tall sprite, strong jump: exercises the ceiling clamp and the x=1 left clamp.
    fighter_motion #(.START_X(1), .SPRITE_H(40), .JUMP_V0(15)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .freeze(freeze),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .x_pos(xb), .y_pos(yb), .airborne(ab), .state(sb_st)
    );

    typedef struct {
        logic       l, r, j, f;
        logic [7:0] ex, ey;
        logic [1:0] est;
    } vec_t;

    typedef struct {
        logic [7:0] x, y;
        logic [1:0] st;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   sel      = 1'b0;

    int prof_y[12] = '{37, 32, 28, 25, 23, 22, 23, 25, 28, 32, 37, 43};
    int prof_s[12] = '{1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 0};

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic addv(input logic l, r, j, f, input int ex, ey, est);
        vec_t v;
        v.l = l; v.r = r; v.j = j; v.f = f;
        v.ex = 8'(ex); v.ey = 8'(ey); v.est = 2'(est);
        vecs.push_back(v);
    endtask

    // Set buttons, optionally pulse jump for 3 clk, let the synchronisers settle, tick once.
    task automatic tick(input vec_t v);
        exp_t e;
        @(negedge clk);
        btn_left = v.l; btn_right = v.r; freeze = v.f;
        if (v.j) begin
            btn_jump = 1'b1;
            repeat (3) @(negedge clk);
            btn_jump = 1'b0;
        end
        repeat (4) @(negedge clk);
        frame_tick = 1'b1;
        e.x = v.ex; e.y = v.ey; e.st = v.est;
        sb.push_back(e);
        @(negedge clk);
        frame_tick = 1'b0;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check(sel ? "b_x" : "a_x", sel ? xb : xa, e.x);
            check(sel ? "b_y" : "a_y", sel ? yb : ya, e.y);
            check(sel ? "b_state" : "a_state", sel ? sb_st : sa, e.st);
            check(sel ? "b_airborne" : "a_airborne", sel ? ab : aa, e.st != 2'd0);
        end
    endtask

    initial begin
        int   xm;
        vec_t v;
        rst_n = 1'b0; frame_tick = 1'b0; freeze = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
        #12;
        check("rst_a_x", xa, 8);
        check("rst_a_y", ya, 43);
        check("rst_a_state", sa, 0);
        check("rst_a_airborne", aa, 0);
        check("rst_b_x", xb, 1);
        check("rst_b_y", yb, 23);
        @(negedge clk) rst_n = 1'b1;

        // Instance B: left clamp from x=1, then ceiling-clamped jump.
        sel = 1'b1;
        addv(1, 0, 0, 0, 0, 23, 0);
        addv(1, 0, 0, 0, 0, 23, 0);
        addv(0, 0, 1, 0, 0, 8, 1);
        addv(0, 0, 0, 0, 0, 0, 2);
        addv(0, 0, 0, 0, 0, 1, 2);
        addv(0, 0, 0, 0, 0, 3, 2);
        addv(0, 0, 0, 0, 0, 6, 2);
        addv(0, 0, 0, 0, 0, 10, 2);
        addv(0, 0, 0, 0, 0, 15, 2);
        addv(0, 0, 0, 0, 0, 21, 2);
        addv(0, 0, 0, 0, 0, 23, 0);
        foreach (vecs[i]) tick(vecs[i]);
        vecs.delete();

        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        sel = 1'b0;

        // Instance A: walk right to the clamp, both buttons, jump profile.
        xm = 8;
        for (int i = 0; i < 45; i++) begin
            xm = (xm + 2 > 83) ? 83 : xm + 2;
            addv(0, 1, 0, 0, xm, 43, 0);
        end
        addv(1, 1, 0, 0, 83, 43, 0);
        // Jump pressed again mid-air (k=7) must be discarded.
        for (int k = 0; k < 12; k++) addv(0, 0, k == 0 || k == 7, 0, 83, prof_y[k], prof_s[k]);
        addv(0, 0, 0, 0, 83, 43, 0);
        addv(0, 0, 0, 0, 83, 43, 0);
        // Jump edge arriving during freeze is dropped.
        addv(0, 0, 1, 1, 83, 43, 0);
        addv(0, 0, 0, 0, 83, 43, 0);
        // Freeze mid-rise holds everything, including horizontal input.
        for (int k = 0; k < 3; k++) addv(0, 0, k == 0, 0, 83, prof_y[k], prof_s[k]);
        for (int k = 0; k < 3; k++) addv(1, 0, 0, 1, 83, 28, 1);
        for (int k = 3; k < 12; k++) addv(0, 0, 0, 0, 83, prof_y[k], prof_s[k]);
        addv(1, 0, 0, 0, 81, 43, 0);
        addv(1, 0, 0, 0, 79, 43, 0);
        addv(1, 0, 0, 0, 77, 43, 0);
        addv(0, 0, 1, 0, 77, 37, 1);
        foreach (vecs[i]) tick(vecs[i]);

        // Asynchronous reset mid-jump, checked before any further clock edge.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_x", xa, 8);
        check("async_rst_y", ya, 43);
        check("async_rst_state", sa, 0);
        check("async_rst_airborne", aa, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
